// File: rtl/fft_axi_wrap.sv
// fft_axi_wrap: AXI4 master shell around the 64-point FFT datapath.
//
// On io_start the block reads a one-beat args block from io_pargs (the data
// pointer lives in RDATA[63:0]), bursts 16 beats of samples from that pointer
// into a 128x32 buffer, runs the core, then bursts the buffer to io_pres.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   io_start / io_done    level start (sampled in IDLE) / one-cycle done pulse
//   io_pargs, io_pres     byte addresses of args and result blocks
//   io_pdata, io_*_len    reserved, ignored
//   io_ap_return          {31'b0, error}, loaded at completion
//   io_m_axi_gmem_*       256-bit AXI4 master (AW/W/B/AR/R)
//
// Build option
//   FFT_CORE_EN  defined: fft64_core transforms the buffer in place during
//                COMPUTE. Undefined: COMPUTE is a single cycle and the buffer
//                is written back unchanged (bus loopback).
module fft_axi_wrap #(
  parameter int AXI_DW = 256,
  parameter int NPTS   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  output logic              io_done,
  input  logic [63:0]       io_pargs,
  input  logic [63:0]       io_pdata,
  input  logic [63:0]       io_pres,
  input  logic [31:0]       io_args_len,
  input  logic [31:0]       io_data_len,
  output logic [31:0]       io_ap_return,
  // write address
  output logic [63:0]       io_m_axi_gmem_AWADDR,
  output logic [7:0]        io_m_axi_gmem_AWLEN,
  output logic [2:0]        io_m_axi_gmem_AWSIZE,
  output logic [1:0]        io_m_axi_gmem_AWBURST,
  output logic [1:0]        io_m_axi_gmem_AWLOCK,
  output logic [3:0]        io_m_axi_gmem_AWREGION,
  output logic [3:0]        io_m_axi_gmem_AWCACHE,
  output logic [2:0]        io_m_axi_gmem_AWPROT,
  output logic [3:0]        io_m_axi_gmem_AWQOS,
  output logic              io_m_axi_gmem_AWVALID,
  input  logic              io_m_axi_gmem_AWREADY,
  // write data
  output logic [AXI_DW-1:0] io_m_axi_gmem_WDATA,
  output logic [AXI_DW/8-1:0] io_m_axi_gmem_WSTRB,
  output logic              io_m_axi_gmem_WLAST,
  output logic              io_m_axi_gmem_WVALID,
  input  logic              io_m_axi_gmem_WREADY,
  // write response
  input  logic [1:0]        io_m_axi_gmem_BRESP,
  input  logic              io_m_axi_gmem_BVALID,
  output logic              io_m_axi_gmem_BREADY,
  // read address
  output logic [63:0]       io_m_axi_gmem_ARADDR,
  output logic [7:0]        io_m_axi_gmem_ARLEN,
  output logic [2:0]        io_m_axi_gmem_ARSIZE,
  output logic [1:0]        io_m_axi_gmem_ARBURST,
  output logic [1:0]        io_m_axi_gmem_ARLOCK,
  output logic [3:0]        io_m_axi_gmem_ARREGION,
  output logic [3:0]        io_m_axi_gmem_ARCACHE,
  output logic [2:0]        io_m_axi_gmem_ARPROT,
  output logic [3:0]        io_m_axi_gmem_ARQOS,
  output logic              io_m_axi_gmem_ARVALID,
  input  logic              io_m_axi_gmem_ARREADY,
  // read data
  input  logic [AXI_DW-1:0] io_m_axi_gmem_RDATA,
  input  logic [1:0]        io_m_axi_gmem_RRESP,
  input  logic              io_m_axi_gmem_RLAST,
  input  logic              io_m_axi_gmem_RVALID,
  output logic              io_m_axi_gmem_RREADY
);

  localparam int NWORDS = 2 * NPTS;        // 128 x 32-bit words
  localparam int WPB    = AXI_DW / 32;     // words per beat (8)

  typedef enum logic [3:0] {
    S_IDLE, S_ARGS_AR, S_ARGS_R, S_DATA_AR, S_DATA_R,
    S_COMPUTE, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [NWORDS-1:0][31:0] buf_q;          // word i in bits [32i+31:32i]
  logic [3:0]              rcnt_q, wcnt_q;
  logic [63:0]             dptr_q;
  logic                    err_q;
  logic [31:0]             ap_ret_q;

  // Beat counting ignores RLAST; the 16th accepted beat ends the read.
  logic unused_ok;
  assign unused_ok = ^{io_pdata, io_args_len, io_data_len, io_m_axi_gmem_RLAST};

  // Constant bus attributes
  assign io_m_axi_gmem_AWSIZE   = 3'd5;
  assign io_m_axi_gmem_AWBURST  = 2'b01;
  assign io_m_axi_gmem_AWLOCK   = '0;
  assign io_m_axi_gmem_AWREGION = '0;
  assign io_m_axi_gmem_AWCACHE  = '0;
  assign io_m_axi_gmem_AWPROT   = '0;
  assign io_m_axi_gmem_AWQOS    = '0;
  assign io_m_axi_gmem_ARSIZE   = 3'd5;
  assign io_m_axi_gmem_ARBURST  = 2'b01;
  assign io_m_axi_gmem_ARLOCK   = '0;
  assign io_m_axi_gmem_ARREGION = '0;
  assign io_m_axi_gmem_ARCACHE  = '0;
  assign io_m_axi_gmem_ARPROT   = '0;
  assign io_m_axi_gmem_ARQOS    = '0;
  assign io_m_axi_gmem_WSTRB    = '1;

  assign io_m_axi_gmem_WDATA = buf_q[{wcnt_q, 3'b000} +: WPB];
  assign io_ap_return        = ap_ret_q;

`ifdef FFT_CORE_EN
  logic        core_start, core_done, core_we, core_run_q;
  logic [6:0]  core_addr;
  logic [31:0] core_rdata, core_wdata;

  assign core_rdata = buf_q[core_addr];

  fft64_core u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (core_start),
    .done      (core_done),
    .mem_addr  (core_addr),
    .mem_rdata (core_rdata),
    .mem_we    (core_we),
    .mem_wdata (core_wdata)
  );

  // core_run_q keeps the start a single pulse while waiting for done
  always_ff @(posedge clock) begin
    if (reset)           core_run_q <= 1'b0;
    else if (core_done)  core_run_q <= 1'b0;
    else if (core_start) core_run_q <= 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and bus outputs; everything is a function of state so
  // VALID/ADDR/LEN hold steady until the handshake moves the state on.
  always_comb begin
    state_d               = state_q;
    io_done               = 1'b0;
    io_m_axi_gmem_ARVALID = 1'b0;
    io_m_axi_gmem_ARADDR  = '0;
    io_m_axi_gmem_ARLEN   = '0;
    io_m_axi_gmem_RREADY  = 1'b0;
    io_m_axi_gmem_AWVALID = 1'b0;
    io_m_axi_gmem_AWADDR  = '0;
    io_m_axi_gmem_AWLEN   = '0;
    io_m_axi_gmem_WVALID  = 1'b0;
    io_m_axi_gmem_WLAST   = 1'b0;
    io_m_axi_gmem_BREADY  = 1'b0;
`ifdef FFT_CORE_EN
    core_start            = 1'b0;
`endif
    case (state_q)
      S_IDLE:    if (io_start) state_d = S_ARGS_AR;
      S_ARGS_AR: begin
        io_m_axi_gmem_ARVALID = 1'b1;
        io_m_axi_gmem_ARADDR  = io_pargs;
        if (io_m_axi_gmem_ARREADY) state_d = S_ARGS_R;
      end
      S_ARGS_R: begin
        io_m_axi_gmem_RREADY = 1'b1;
        if (io_m_axi_gmem_RVALID) state_d = S_DATA_AR;
      end
      S_DATA_AR: begin
        io_m_axi_gmem_ARVALID = 1'b1;
        io_m_axi_gmem_ARADDR  = dptr_q;
        io_m_axi_gmem_ARLEN   = 8'd15;
        if (io_m_axi_gmem_ARREADY) state_d = S_DATA_R;
      end
      S_DATA_R: begin
        io_m_axi_gmem_RREADY = 1'b1;
        if (io_m_axi_gmem_RVALID && rcnt_q == 4'd15) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
`ifdef FFT_CORE_EN
        core_start = !core_run_q;
        if (core_done) state_d = S_AW;
`else
        state_d = S_AW;
`endif
      end
      S_AW: begin
        io_m_axi_gmem_AWVALID = 1'b1;
        io_m_axi_gmem_AWADDR  = io_pres;
        io_m_axi_gmem_AWLEN   = 8'd15;
        if (io_m_axi_gmem_AWREADY) state_d = S_W;
      end
      S_W: begin
        io_m_axi_gmem_WVALID = 1'b1;
        io_m_axi_gmem_WLAST  = (wcnt_q == 4'd15);
        if (io_m_axi_gmem_WREADY && wcnt_q == 4'd15) state_d = S_B;
      end
      S_B: begin
        io_m_axi_gmem_BREADY = 1'b1;
        if (io_m_axi_gmem_BVALID) state_d = S_DONE;
      end
      S_DONE: begin
        io_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, pointer, error flag, status
  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt_q   <= '0;
      wcnt_q   <= '0;
      dptr_q   <= '0;
      err_q    <= 1'b0;
      ap_ret_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (io_start) begin
          err_q  <= 1'b0;
          rcnt_q <= '0;
          wcnt_q <= '0;
        end
        S_ARGS_R: if (io_m_axi_gmem_RVALID) begin
          dptr_q <= io_m_axi_gmem_RDATA[63:0];
          if (io_m_axi_gmem_RRESP != 2'b00) err_q <= 1'b1;
        end
        S_DATA_R: if (io_m_axi_gmem_RVALID) begin
          rcnt_q <= rcnt_q + 4'd1;
          if (io_m_axi_gmem_RRESP != 2'b00) err_q <= 1'b1;
        end
        S_W: if (io_m_axi_gmem_WREADY) wcnt_q <= wcnt_q + 4'd1;
        S_B: if (io_m_axi_gmem_BVALID && io_m_axi_gmem_BRESP != 2'b00) err_q <= 1'b1;
        S_DONE: ap_ret_q <= {31'b0, err_q};
        default: ;
      endcase
    end
  end

  // Sample buffer: filled from the read burst, optionally rewritten by the core
  always_ff @(posedge clock) begin
    if (state_q == S_DATA_R && io_m_axi_gmem_RVALID)
      buf_q[{rcnt_q, 3'b000} +: WPB] <= io_m_axi_gmem_RDATA;
`ifdef FFT_CORE_EN
    else if (core_we)
      buf_q[core_addr] <= core_wdata;
`endif
  end

endmodule

// File: tb/tb_fft_axi_wrap.sv
module tb_fft_axi_wrap;

  logic         clock = 1'b0;
  logic         reset, io_start, io_done;
  logic [63:0]  io_pargs, io_pdata, io_pres;
  logic [31:0]  io_args_len, io_data_len, io_ap_return;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize, awprot, arprot;
  logic [1:0]   awburst, arburst, awlock, arlock;
  logic [3:0]   awregion, arregion, awcache, arcache, awqos, arqos;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [255:0] wdata, rdata;
  logic [31:0]  wstrb;
  logic [1:0]   bresp, rresp;

  always #5 clock = ~clock;

  fft_axi_wrap dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_done(io_done),
    .io_pargs(io_pargs), .io_pdata(io_pdata), .io_pres(io_pres),
    .io_args_len(io_args_len), .io_data_len(io_data_len), .io_ap_return(io_ap_return),
    .io_m_axi_gmem_AWADDR(awaddr), .io_m_axi_gmem_AWLEN(awlen), .io_m_axi_gmem_AWSIZE(awsize),
    .io_m_axi_gmem_AWBURST(awburst), .io_m_axi_gmem_AWLOCK(awlock), .io_m_axi_gmem_AWREGION(awregion),
    .io_m_axi_gmem_AWCACHE(awcache), .io_m_axi_gmem_AWPROT(awprot), .io_m_axi_gmem_AWQOS(awqos),
    .io_m_axi_gmem_AWVALID(awvalid), .io_m_axi_gmem_AWREADY(awready),
    .io_m_axi_gmem_WDATA(wdata), .io_m_axi_gmem_WSTRB(wstrb), .io_m_axi_gmem_WLAST(wlast),
    .io_m_axi_gmem_WVALID(wvalid), .io_m_axi_gmem_WREADY(wready),
    .io_m_axi_gmem_BRESP(bresp), .io_m_axi_gmem_BVALID(bvalid), .io_m_axi_gmem_BREADY(bready),
    .io_m_axi_gmem_ARADDR(araddr), .io_m_axi_gmem_ARLEN(arlen), .io_m_axi_gmem_ARSIZE(arsize),
    .io_m_axi_gmem_ARBURST(arburst), .io_m_axi_gmem_ARLOCK(arlock), .io_m_axi_gmem_ARREGION(arregion),
    .io_m_axi_gmem_ARCACHE(arcache), .io_m_axi_gmem_ARPROT(arprot), .io_m_axi_gmem_ARQOS(arqos),
    .io_m_axi_gmem_ARVALID(arvalid), .io_m_axi_gmem_ARREADY(arready),
    .io_m_axi_gmem_RDATA(rdata), .io_m_axi_gmem_RRESP(rresp), .io_m_axi_gmem_RLAST(rlast),
    .io_m_axi_gmem_RVALID(rvalid), .io_m_axi_gmem_RREADY(rready)
  );

  typedef struct {
    logic [63:0] pargs;
    logic [63:0] dptr;
    logic [63:0] pres;
    logic [31:0] base;     // word i of the samples = base + i
    int          err_beat; // data beat returning SLVERR, -1 for none
    logic [1:0]  bresp;
    bit          toggle;   // WREADY alternates every cycle
    logic [31:0] exp_ret;
  } tcase_t;

  tcase_t         tbl[4];
  logic [255:0]   sb[$];
  int             checks = 0;
  int             passes = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return arvalid;
      1: return rready;
      2: return awvalid;
      3: return bready;
      4: return io_done;
      default: return wvalid;
    endcase
  endfunction

  // Advance negedge by negedge until the selected output is high.
  task automatic wait_sig(input string nm, input int which);
    int n = 0;
    while (sig(which) !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (sig(which) !== 1'b1) begin
      checks++;
      $display("FAIL timeout_%s: got no assertion in 64 cycles, want assertion", nm);
    end
  endtask

  function automatic logic [255:0] beat_of(input logic [31:0] base, input int b);
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = base + 32'(8*b + j);
    return v;
  endfunction

  // Start through AW handshake; expected W beats go to the scoreboard.
  task automatic fetch_phase(input tcase_t tc);
    io_pargs = tc.pargs;
    io_pres  = tc.pres;
    arready  = 1'b1;
    awready  = 1'b1;
    io_start = 1'b1;
    step();
    chk("arvalid_latency", arvalid, 1'b1);
    wait_sig("args_ar", 0);
    chk("args_araddr", araddr, tc.pargs);
    chk("args_arlen", arlen, 8'd0);
    chk("arsize", arsize, 3'd5);
    chk("arburst", arburst, 2'b01);
    step();
    io_start = 1'b0;
    wait_sig("args_r", 1);
    rdata  = {192'hdead, tc.dptr};
    rresp  = 2'b00;
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    wait_sig("data_ar", 0);
    chk("data_araddr", araddr, tc.dptr);
    chk("data_arlen", arlen, 8'd15);
    step();
    for (int b = 0; b < 16; b++) begin
      wait_sig("data_r", 1);
      rdata  = beat_of(tc.base, b);
      rresp  = (b == tc.err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == 15);
      rvalid = 1'b1;
      sb.push_back(rdata);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    wait_sig("aw", 2);
    chk("awaddr", awaddr, tc.pres);
    chk("awlen", awlen, 8'd15);
    chk("awsize", awsize, 3'd5);
    chk("wstrb", wstrb, 32'hffff_ffff);
    step();
  endtask

  task automatic write_phase(input tcase_t tc);
    int cnt = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [255:0] last = '0;
    logic [255:0] exp;
    while (cnt < 16 && cyc < 200) begin
      wready = tc.toggle ? cyc[0] : 1'b1;
      if (wvalid) begin
        if (stalled) chk("w_stable", wdata, last);
        if (wready) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL w_extra: got beat %0d with empty scoreboard, want none", cnt);
          end else begin
            exp = sb.pop_front();
            chk("w_data", wdata, exp);
          end
          chk("w_last", wlast, (cnt == 15));
          cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          last    = wdata;
        end
      end
      step();
      cyc++;
    end
    wready = 1'b1;
    if (cnt < 16) begin
      checks++;
      $display("FAIL timeout_w: got %0d beats, want 16", cnt);
    end
    chk("w_after_last", wvalid, 1'b0);
    wait_sig("b", 3);
    bresp  = tc.bresp;
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    bresp  = 2'b00;
    wait_sig("done", 4);
    step();
    chk("done_pulse_width", io_done, 1'b0);
    chk("ap_return", io_ap_return, tc.exp_ret);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'h0, 64'h0ff000000, 64'hf00000000, 32'h0, -1, 2'b00, 1'b0, 32'd0};
    tbl[1] = '{64'h1000, 64'h2000_0040, 64'h3000, 32'h1000, 3, 2'b00, 1'b0, 32'd1};
    tbl[2] = '{64'h8, 64'h7fff_0000_0004, 64'h44, 32'ha5a5_0000, -1, 2'b00, 1'b1, 32'd0};
    tbl[3] = '{64'h20, 64'h400, 64'h800, 32'h3f80_0000, -1, 2'b10, 1'b0, 32'd1};

    reset = 1'b1; io_start = 1'b0; io_pargs = '0; io_pdata = '0; io_pres = '0;
    io_args_len = '0; io_data_len = '0;
    awready = 1'b0; wready = 1'b1; bresp = '0; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    step(); step();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_done", io_done, 1'b0);
    chk("rst_ap_return", io_ap_return, 32'd0);
    reset = 1'b0;
    step();

    // Stray R beat in IDLE must be refused
    rvalid = 1'b1;
    chk("idle_rready", rready, 1'b0);
    step();
    rvalid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      fetch_phase(tbl[i]);
      write_phase(tbl[i]);
      if (sb.size() != 0) begin
        checks++;
        $display("FAIL sb_leftover: got %0d beats, want 0", sb.size());
        sb.delete();
      end
    end

    // Abort while stalled in W
    fetch_phase(tbl[2]);
    wready = 1'b0;
    wait_sig("w_abort", 5);
    step();
    reset = 1'b1;
    step();
    chk("abort_wvalid", wvalid, 1'b0);
    chk("abort_awvalid", awvalid, 1'b0);
    chk("abort_arvalid", arvalid, 1'b0);
    chk("abort_bready", bready, 1'b0);
    chk("abort_rready", rready, 1'b0);
    chk("abort_done", io_done, 1'b0);
    reset  = 1'b0;
    wready = 1'b1;
    sb.delete();
    step();

    // Recovery run after the abort
    fetch_phase(tbl[0]);
    write_phase(tbl[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
